// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous pulse train
// in clk0 cycles, with a loss-of-signal timeout. Optional glitch filter: GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned CW       = 20,
    parameter int unsigned TIMEOUT  = 1048575,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic          clk0,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] period_cnt,
    output logic          meas_valid,
    output logic          timeout,
    output logic          no_signal
);

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          prev_f_q;
    logic          f_c;
    logic          rise_c;
    logic          fall_c;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc_c;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] high_q;
    logic [CW-1:0] period_q;
    logic          valid_q;
    logic          timeout_q;
    logic          no_sig_q;

    // Two-flop synchronizer plus the one-cycle delayed copy used for edge detection
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_f_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            prev_f_q <= f_c;
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;
    logic          filt_q;
    logic          filt_d;

    // Follow s only after it has disagreed with f for FILT_LEN consecutive cycles
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign f_c = filt_q;
`else
    assign f_c = sync2_q;

    // FILT_LEN only shapes the optional filter
    if (FILT_LEN == 0) begin : g_filt_len_unused
    end
`endif

    assign rise_c    = f_c & ~prev_f_q;
    assign fall_c    = ~f_c & prev_f_q;
    assign cnt_inc_c = (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);

    // Measurement FSM; cnt restarts at 1 on every rise so it reads H at fall and P at rise
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            no_sig_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise_c) begin
                        state_q <= HIGH;
                        cnt_q   <= CW'(1);
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        state_q <= LOW;
                        hold_q  <= cnt_q;
                        cnt_q   <= cnt_inc_c;
                    end else if (cnt_q == TMO) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                        no_sig_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                LOW: begin
                    if (rise_c) begin
                        state_q  <= HIGH;
                        cnt_q    <= CW'(1);
                        period_q <= cnt_q;
                        high_q   <= hold_q;
                        valid_q  <= 1'b1;
                        no_sig_q <= 1'b0;
                    end else if (cnt_q == TMO) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                        no_sig_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;
    assign no_signal  = no_sig_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed plus randomized pulse trains, checked every cycle against a
// timestamp-based reference model of the capture rules.
module tb_pwm_capture;

    localparam int unsigned CW  = 8;
    localparam int unsigned TMO = 200;
    localparam int unsigned FL  = 4;
`ifdef GLITCH_FILTER_EN
    localparam bit          FILT = 1'b1;
    localparam int unsigned DLY  = 3;
`else
    localparam bit          FILT = 1'b0;
    localparam int unsigned DLY  = 2;
`endif

    logic          clk0   = 1'b0;
    logic          rst_n  = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic          meas_valid;
    logic          timeout;
    logic          no_signal;

    pwm_capture #(.CW(CW), .TIMEOUT(TMO), .FILT_LEN(FL)) dut (
        .clk0       (clk0),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .no_signal  (no_signal)
    );

    always #5 clk0 = ~clk0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: timestamps of last rise/fall on the (optionally filtered) sample stream
    typedef struct {
        bit mv;
        bit to;
        bit ns;
        int hi;
        int per;
    } obs_t;

    obs_t pipe[$];
    obs_t cur;
    obs_t mdl;
    bit   y;
    bit   y_prev;
    int   run;
    int   rise_t;
    int   fall_t;
    int   stored_hi;
    int   n;

    int cyc     = 0;
    int mv_cnt  = 0;
    int to_cnt  = 0;
    int last_mv = 0;
    int mv_gap  = 0;
    int to_cyc  = 0;

    task automatic model_reset();
        pipe.delete();
        cur       = '{default: 0};
        mdl       = '{default: 0};
        y         = 1'b0;
        y_prev    = 1'b0;
        run       = 0;
        rise_t    = -1;
        fall_t    = -1;
        stored_hi = 0;
        n         = 0;
    endtask

    task automatic model_step(input bit x);
        int  age;
        bit  rise;
        bit  fall;
        if (FILT) begin
            if (x != y) begin
                run++;
                if (run == int'(FL)) begin
                    y   = x;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end else begin
            y = x;
        end
        rise   = y && !y_prev;
        fall   = !y && y_prev;
        y_prev = y;
        mdl.mv = 1'b0;
        mdl.to = 1'b0;
        if (rise_t < 0) begin
            if (rise) begin
                rise_t = n;
                fall_t = -1;
            end
        end else begin
            age = (n - rise_t > int'(TMO)) ? int'(TMO) : n - rise_t;
            if (rise && fall_t >= 0) begin
                mdl.mv  = 1'b1;
                mdl.per = age;
                mdl.hi  = stored_hi;
                mdl.ns  = 1'b0;
                rise_t  = n;
                fall_t  = -1;
            end else if (fall && fall_t < 0) begin
                fall_t    = n;
                stored_hi = age;
            end else if (!rise && !fall && age == int'(TMO)) begin
                mdl.to = 1'b1;
                mdl.ns = 1'b1;
                rise_t = -1;
            end
        end
        n++;
        pipe.push_back(mdl);
        if (pipe.size() > int'(DLY)) cur = pipe.pop_front();
    endtask

    // Step the model on each edge, then compare all outputs just after it
    always @(posedge clk0) begin
        if (!rst_n) model_reset();
        else model_step(pwm_in);
        #1;
        check("meas_valid", 32'(meas_valid), 32'(cur.mv));
        check("timeout", 32'(timeout), 32'(cur.to));
        check("no_signal", 32'(no_signal), 32'(cur.ns));
        check("high_cnt", 32'(high_cnt), cur.hi);
        check("period_cnt", 32'(period_cnt), cur.per);
        check("mv_to_excl", 32'(meas_valid & timeout), 0);
        if (meas_valid === 1'b1) begin
            mv_cnt++;
            mv_gap  = cyc - last_mv;
            last_mv = cyc;
        end
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        cyc++;
    end

    task automatic drive(input logic lvl, input int cycles);
        pwm_in = lvl;
        repeat (cycles) @(negedge clk0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high"}, 32'(high_cnt), 0);
        check({tag, "_period"}, 32'(period_cnt), 0);
        check({tag, "_mv"}, 32'(meas_valid), 0);
        check({tag, "_to"}, 32'(timeout), 0);
        check({tag, "_ns"}, 32'(no_signal), 0);
    endtask

    int mv0;
    int h;
    int l;

    initial begin
        repeat (3) @(negedge clk0);
        check_zero("reset");
        rst_n = 1'b1;

        // First period after reset is discarded, second one reported
        drive(1'b1, 60);
        check("first_rise_no_valid", mv_cnt, 0);
        drive(1'b0, 100);
        drive(1'b1, 10);
        check("second_rise_valid", mv_cnt, 1);
        check("second_rise_high", 32'(high_cnt), 60);
        check("second_rise_period", 32'(period_cnt), 160);

        // Loss of signal: timeout TMO cycles after the last rise, results retained
        drive(1'b0, 250);
        check("to_count", to_cnt, 1);
        check("to_after_rise", to_cyc - last_mv, TMO);
        check("to_no_signal", 32'(no_signal), 1);
        check("to_hold_high", 32'(high_cnt), 60);
        check("to_hold_period", 32'(period_cnt), 160);

        // Steady train from idle: 4 periods give 3 strobes
        mv0 = mv_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 30);
            if (i == 0) begin
                check("resume_no_valid", mv_cnt - mv0, 0);
                check("resume_ns_still", 32'(no_signal), 1);
            end
            drive(1'b0, 70);
        end
        check("steady_strobes", mv_cnt - mv0, 3);
        check("steady_gap", mv_gap, 100);
        check("steady_high", 32'(high_cnt), 30);
        check("steady_period", 32'(period_cnt), 100);
        check("steady_ns_clear", 32'(no_signal), 0);
        drive(1'b0, 150);
        check("steady_to", to_cnt, 2);

        // Period exactly TMO: the edge wins over the timeout
        drive(1'b1, 50);
        drive(1'b0, 150);
        drive(1'b1, 50);
        drive(1'b0, 150);
        drive(1'b1, 5);
        check("bound_period", 32'(period_cnt), 200);
        check("bound_high", 32'(high_cnt), 50);
        check("bound_no_to", to_cnt, 2);

        // Period TMO+1: timeout fires and the late rise measures nothing
        mv0 = mv_cnt;
        drive(1'b0, 196);
        drive(1'b1, 20);
        check("over_to", to_cnt, 3);
        check("over_no_valid", mv_cnt - mv0, 0);
        check("over_hold_period", 32'(period_cnt), 200);

        // Two-cycle glitch inside a low phase
        drive(1'b0, 80);
        drive(1'b1, 30);
        drive(1'b0, 30);
        drive(1'b1, 2);
        drive(1'b0, 38);
        drive(1'b1, 10);
        if (FILT) begin
            check("glitch_high", 32'(high_cnt), 30);
            check("glitch_period", 32'(period_cnt), 100);
        end else begin
            check("glitch_high", 32'(high_cnt), 2);
            check("glitch_period", 32'(period_cnt), 40);
        end

        // Reset pulse during a high phase
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk0);
        rst_n = 1'b1;
        mv0 = mv_cnt;
        drive(1'b1, 20);
        drive(1'b0, 50);
        check("midreset_no_valid", mv_cnt - mv0, 0);
        drive(1'b1, 30);
        drive(1'b0, 70);

        // Randomized trains, including short pulses and timeouts
        for (int i = 0; i < 150; i++) begin
            h = int'($urandom_range(1, 90));
            l = int'($urandom_range(1, 90));
            if ($urandom_range(0, 9) == 0) l = int'($urandom_range(150, 260));
            drive(1'b1, h);
            drive(1'b0, l);
        end
        drive(1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
